line_clear: RTL and testbench

Scans the `ram_board` playfield after a piece has been locked into it. It removes every completely filled row, shifts everything above each removed row down by one, and reports how many rows were removed. It sits downstream of the piece-lock step in `control`. While `busy` is high, `control` muxes the single `ram_board` port over to this block. When `done` pulses, `control` takes the port back, adds `lines_cleared` to the score and requests the next piece.

---
 rtl/line_clear.sv | 185 ++++++++++++++++++
 tb/tb_line_clear.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear.sv
// line_clear: removes every completely filled row from the board RAM after a
// piece lock, shifting the rows above down, and reports the number removed.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   start         begin a scan (only sampled while idle)
//   ram_addr      board RAM address, row*BOARD_W + col
//   ram_wdata     colour written to RAM (0 when not writing)
//   ram_wren      RAM write enable
//   ram_rdata     RAM read data, valid the cycle after the address
//   busy          high while this block owns the RAM port, through DONE
//   done          one-cycle completion pulse
//   lines_cleared rows removed in the last run, saturating at 7
module line_clear #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_wdata,
  output logic       ram_wren,
  input  logic [5:0] ram_rdata,
  output logic       busy,
  output logic       done,
  output logic [2:0] lines_cleared
);

  localparam int unsigned RowW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
  // Column counter must also hold BOARD_W: the extra scan cycle checking the last cell.
  localparam int unsigned ColW = $clog2(BOARD_W + 1);

  localparam logic [RowW-1:0] RowLast = RowW'(BOARD_H - 1);
  localparam logic [RowW-1:0] RowOne  = RowW'(1);
  localparam logic [RowW-1:0] RowZero = RowW'(0);
  localparam logic [ColW-1:0] ColLast = ColW'(BOARD_W - 1);
  localparam logic [ColW-1:0] ColEnd  = ColW'(BOARD_W);
  localparam logic [ColW-1:0] ColOne  = ColW'(1);
  localparam logic [ColW-1:0] ColZero = ColW'(0);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StShiftRd,
    StShiftWr,
    StClearTop,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [RowW-1:0] row_q, row_d;   // row being scanned
  logic [RowW-1:0] dst_q, dst_d;   // destination row while shifting
  logic [ColW-1:0] col_q, col_d;
  logic            full_q, full_d; // all cells checked so far in this row are non-zero
  logic [2:0]      lines_q, lines_d;
  logic            cell_nz;

  function automatic logic [7:0] cell_addr(input logic [RowW-1:0] row,
                                           input logic [ColW-1:0] col);
    return 8'(row) * 8'(BOARD_W) + 8'(col);
  endfunction

  assign cell_nz = |ram_rdata;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dst_d     = dst_q;
    col_d     = col_q;
    full_d    = full_q;
    lines_d   = lines_q;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          row_d   = RowLast;
          col_d   = ColZero;
          lines_d = 3'd0;
        end
      end

      StScan: begin
        // Address for column col_q goes out now; its data is checked at col_q+1.
        if (col_q != ColEnd) begin
          ram_addr = cell_addr(row_q, col_q);
        end
        if (col_q == ColZero) begin
          full_d = 1'b1;
        end else begin
          full_d = full_q & cell_nz;
        end

        if (col_q == ColEnd) begin
          col_d = ColZero;
          if (full_q && cell_nz) begin
            if (lines_q != 3'd7) begin
              lines_d = lines_q + 3'd1;
            end
            dst_d   = row_q;
            // Row 0 has nothing above it to copy down.
            state_d = (row_q == RowZero) ? StClearTop : StShiftRd;
          end else if (row_q != RowZero) begin
            row_d = row_q - RowOne;
          end else begin
            state_d = StDone;
          end
        end else begin
          col_d = col_q + ColOne;
        end
      end

      StShiftRd: begin
        ram_addr = cell_addr(dst_q - RowOne, col_q);
        state_d  = StShiftWr;
      end

      StShiftWr: begin
        ram_addr  = cell_addr(dst_q, col_q);
        ram_wren  = 1'b1;
        ram_wdata = ram_rdata;
        state_d   = StShiftRd;
        if (col_q == ColLast) begin
          col_d = ColZero;
          if (dst_q == RowOne) begin
            state_d = StClearTop;
          end else begin
            dst_d = dst_q - RowOne;
          end
        end else begin
          col_d = col_q + ColOne;
        end
      end

      StClearTop: begin
        ram_addr = cell_addr(RowZero, col_q);
        ram_wren = 1'b1;
        if (col_q == ColLast) begin
          col_d = ColZero;
          // Rescan the same row: the row above has just moved into it.
          state_d = StScan;
        end else begin
          col_d = col_q + ColOne;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      dst_q   <= '0;
      col_q   <= '0;
      full_q  <= 1'b0;
      lines_q <= 3'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dst_q   <= dst_d;
      col_q   <= col_d;
      full_q  <= full_d;
      lines_q <= lines_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear.sv
// Bench for line_clear: owns a write-first single-port board RAM, predicts the
// final board, line count, run length and write count from the row-removal rules,
// and checks busy/done/wdata every cycle of a run.
module tb_line_clear;

  localparam int W = 10;
  localparam int H = 20;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] ram_addr;
  logic [5:0] ram_wdata;
  logic       ram_wren;
  logic [5:0] ram_rdata;
  logic       busy;
  logic       done;
  logic [2:0] lines_cleared;

  always #5 clk = ~clk;

  line_clear #(
    .BOARD_W(W),
    .BOARD_H(H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wren     (ram_wren),
    .ram_rdata    (ram_rdata),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared)
  );

  // Board RAM with a bench backdoor for loading.
  logic [5:0] mem [N];
  logic       tb_clr = 1'b0;
  logic       tb_we  = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [5:0] tb_data = '0;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram_wren ? ram_wdata : mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model results.
  logic [5:0] exp_mem [N];
  int exp_lines, exp_tot, exp_wr;
  int k_cyc = 0;
  bit mon_en = 1'b0;
  int wr_seen = 0;
  int done_cyc = -1;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", int'(busy), int'(cyc >= k_cyc && cyc <= k_cyc + exp_tot));
      check("done", int'(done), int'(cyc == k_cyc + exp_tot));
      if (!ram_wren) check("wdata_idle", int'(ram_wdata), 0);
      if (ram_wren) wr_seen++;
      if (done) done_cyc = cyc;
    end
  end

  task automatic build_model();
    int b [H][W];
    int r, cnt, dst;
    bit fin, full;
    for (int rr = 0; rr < H; rr++)
      for (int c = 0; c < W; c++) b[rr][c] = int'(mem[rr*W + c]);

    // Run length and write count from the row-by-row procedure.
    exp_tot = 0; exp_wr = 0; cnt = 0; r = H - 1; fin = 1'b0;
    while (!fin) begin
      exp_tot += W + 1;
      full = 1'b1;
      for (int c = 0; c < W; c++) if (b[r][c] == 0) full = 1'b0;
      if (full) begin
        cnt++;
        exp_tot += 2*W*r + W;
        exp_wr  += W*r + W;
        for (int d = r; d > 0; d--)
          for (int c = 0; c < W; c++) b[d][c] = b[d-1][c];
        for (int c = 0; c < W; c++) b[0][c] = 0;
      end else if (r > 0) begin
        r--;
      end else begin
        fin = 1'b1;
      end
    end
    exp_lines = (cnt > 7) ? 7 : cnt;

    // Final board: surviving rows compacted to the bottom, zeros on top.
    dst = H - 1;
    for (int src = H - 1; src >= 0; src--) begin
      full = 1'b1;
      for (int c = 0; c < W; c++) if (mem[src*W + c] == 6'd0) full = 1'b0;
      if (!full) begin
        for (int c = 0; c < W; c++) exp_mem[dst*W + c] = mem[src*W + c];
        dst--;
      end
    end
    for (int rr = 0; rr <= dst; rr++)
      for (int c = 0; c < W; c++) exp_mem[rr*W + c] = '0;
  endtask

  task automatic clear_board();
    @(negedge clk); tb_clr = 1'b1;
    @(negedge clk); tb_clr = 1'b0;
  endtask

  task automatic set_cell(input int r, input int c, input logic [5:0] v);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = 8'(r*W + c); tb_data = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic set_row(input int r, input logic [5:0] v);
    for (int c = 0; c < W; c++) set_cell(r, c, v);
  endtask

  // restart_off >= 0 pulses start again that many cycles into the run.
  task automatic run(input string name, input int restart_off);
    int bad;
    @(negedge clk);
    build_model();
    wr_seen  = 0;
    done_cyc = -1;
    start  = 1'b1;
    k_cyc  = cyc + 1;
    mon_en = 1'b1;
    for (int i = 0; i <= exp_tot + 2; i++) begin
      @(negedge clk);
      start = (i == restart_off);
    end
    start  = 1'b0;
    mon_en = 1'b0;
    check({name, "_lines"}, int'(lines_cleared), exp_lines);
    check({name, "_writes"}, wr_seen, exp_wr);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) bad++;
    check({name, "_board_bad_cells"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("rst_addr",  int'(ram_addr), 0);
    check("rst_wdata", int'(ram_wdata), 0);
    check("rst_wren",  int'(ram_wren), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_lines", int'(lines_cleared), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Empty board.
    clear_board();
    run("empty", -1);
    check("empty_latency", done_cyc - k_cyc, 220);
    check("empty_lit_lines", int'(lines_cleared), 0);
    check("empty_lit_writes", wr_seen, 0);

    // Row 19 full, marker above; a second start mid-scan must be ignored.
    clear_board();
    set_row(19, 6'h05);
    set_cell(18, 3, 6'h0A);
    run("row19", 5);
    check("row19_latency", done_cyc - k_cyc, 621);
    check("row19_lit_lines", int'(lines_cleared), 1);
    check("row19_cell_19_3", int'(mem[19*W + 3]), 'h0A);
    check("row19_cell_19_0", int'(mem[19*W + 0]), 0);
    check("row19_cell_18_3", int'(mem[18*W + 3]), 0);

    // Four stacked full rows.
    clear_board();
    for (int r = 16; r < 20; r++) set_row(r, 6'h07);
    set_cell(15, 0, 6'h3F);
    run("four", -1);
    check("four_lit_lines", int'(lines_cleared), 4);
    check("four_cell_19_0", int'(mem[19*W + 0]), 'h3F);
    check("four_cell_15_0", int'(mem[15*W + 0]), 0);

    // Rows 19 and 17 full, row 18 with a gap at column 4.
    clear_board();
    set_row(19, 6'h01);
    set_row(17, 6'h02);
    for (int c = 0; c < W; c++) if (c != 4) set_cell(18, c, 6'h03);
    run("gap", -1);
    check("gap_lit_lines", int'(lines_cleared), 2);
    check("gap_cell_19_4", int'(mem[19*W + 4]), 0);
    check("gap_cell_19_5", int'(mem[19*W + 5]), 3);
    check("gap_cell_17_0", int'(mem[17*W + 0]), 0);

    // Only row 0 full: clear-top only, no shift writes.
    clear_board();
    set_row(0, 6'h09);
    set_cell(5, 2, 6'h04);
    run("top", -1);
    check("top_lit_lines", int'(lines_cleared), 1);
    check("top_lit_writes", wr_seen, W);
    check("top_latency", done_cyc - k_cyc, 241);
    check("top_cell_0_0", int'(mem[0]), 0);
    check("top_cell_5_2", int'(mem[5*W + 2]), 4);

    // Reset in the middle of the first shift write.
    clear_board();
    set_row(19, 6'h06);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ram_wren) got = 1'b1;
    end
    check("rst_mid_reached_shift", int'(got), 1);
    check("rst_mid_pre_lines", int'(lines_cleared), 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy",  int'(busy), 0);
    check("rst_mid_done",  int'(done), 0);
    check("rst_mid_wren",  int'(ram_wren), 0);
    check("rst_mid_lines", int'(lines_cleared), 0);
    @(negedge clk);
    reset = 1'b0;
    run("fresh", -1);
    check("fresh_latency", done_cyc - k_cyc, 621);
    check("fresh_lit_lines", int'(lines_cleared), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
